hdlc_rx_deframer: RTL and testbench
===================================

HDLC_RX_DEFRAMER -- requirements
Module: hdlc_rx_deframer

Interface
REQ-001 Parameter MAX_FRAME_BYTES, default 128: maximum data bytes accepted between an opening and a closing flag.
REQ-002 clk_i  in  1  single block clock; all logic is on its rising edge.
REQ-003 rstn_i  in  1  reset, asynchronous, active-low.
REQ-004 en_i  in  1  block enable; low forces HUNT.
REQ-005 rxen_i  in  1  bit strobe; one clk_i cycle high per received line bit.
REQ-006 rx_i  in  1  serial line data, sampled only when rxen_i=1.
REQ-007 rxd_o  out  8  received data byte; the first received bit is rxd_o[0].
REQ-008 rxd_valid_o  out  1  one-cycle pulse; rxd_o is valid.
REQ-009 eof_o  out  1  one-cycle pulse; good frame end (byte-aligned closing flag).
REQ-010 frame_err_o  out  1  one-cycle pulse; misaligned closing flag or MAX_FRAME_BYTES exceeded.
REQ-011 abort_o  out  1  one-cycle pulse; abort (7 consecutive ones) seen inside a frame.

Function
REQ-012 Ones counter, 3 bits, saturating at 7; updated only on sampled bits (en_i=1, rxen_i=1).
- Bit 1 -> counter+1.
- Bit 0 -> counter cleared.
REQ-013 Sampled bit classification (counter value before update):
- 0 with count 5: stuffed zero, discarded.
- 0 with count 6: flag.
- 1 with count 6: abort.
- 1 with count <=4, or 0 with count <=4: data bit.
- 1 with count 5: not a data bit.
REQ-014 Data bits shift into an 8-bit register LSB-first; a 3-bit bit counter wraps 7->0.
REQ-015 On the wrap, the byte is presented on rxd_o with rxd_valid_o=1 in the next clk_i cycle, and the byte counter increments.
REQ-016 States HUNT, FLAG, DATA. Transitions:
- HUNT -> FLAG on flag.
- FLAG -> FLAG on flag; bit and byte counters cleared; no output.
- FLAG -> DATA on first byte completion.
- DATA -> FLAG on flag.
- Any state -> HUNT on abort.
REQ-017 Bytes complete only in FLAG or DATA; data bits in HUNT are discarded.
REQ-018 Flag in DATA with bit counter = 6: eof_o pulses; otherwise frame_err_o pulses. In both cases the next state is FLAG, because the closing flag is also the opening flag of the next frame.
REQ-019 A misaligned frame may emit one spurious final byte before frame_err_o; downstream discards the whole frame on frame_err_o.
REQ-020 Abort in DATA pulses abort_o; abort in HUNT or FLAG pulses nothing.
REQ-021 Byte completion that would exceed MAX_FRAME_BYTES:
- frame_err_o pulses; the byte is not emitted.
- State -> HUNT.
REQ-022 Outputs are registered, one clk_i cycle after the deciding rxen_i cycle. At most one of eof_o, frame_err_o and abort_o is high in any cycle.
REQ-023 rxd_valid_o never coincides with eof_o.
REQ-024 en_i=0: synchronous clear of state (HUNT), all counters and pulses; rxd_o holds its value.
REQ-025 No FCS checking in this block; FCS bytes are delivered as data.

Reset
REQ-026 rstn_i low asynchronously sets:
- state = HUNT;
- ones, bit and byte counters = 0;
- shift register = 0 and rxd_o = 8'h00;
- all pulse outputs = 0.
REQ-027 Reset mid-frame discards the partial frame with no eof_o, frame_err_o or abort_o. After release, a flag is required before any data.

Structure
REQ-028 Shared package hdlc_pkg holds:
- state enum (HUNT, FLAG, DATA);
- flag constant 8'h7E;
- stuff threshold 5 and abort threshold 7.
REQ-029 One sub-module, hdlc_rx_destuff: ones counter plus bit classification (data, stuffed, flag, abort); the top holds the FSM and assembly.

Verification
REQ-030 Stimulus: 7E, A5, 7E (LSB first) -> rxd_valid_o once with rxd_o=A5, then eof_o once.
REQ-031 Stimulus: 7E, payload 1F stuffed on the line as 1,1,1,1,1,0,0,0,0, then 7E -> rxd_o=1F once, eof_o; the stuffed zero is not counted.
REQ-032 Stimulus: 7E, A5, seven 1s -> A5 emitted, then abort_o once, no eof_o. A following A5 without a flag -> no output.
REQ-033 Stimulus: 7E, 11 data bits, 7E -> frame_err_o once, no eof_o.
REQ-034 Stimulus: 7E 7E 7E 3C 7E -> only 3C and one eof_o. With MAX_FRAME_BYTES=4, five bytes -> four bytes emitted then frame_err_o.
REQ-035 Stimulus: rstn_i pulsed low mid-byte -> all outputs 0 immediately; a subsequent 7E, 55, 7E yields 55 and eof_o.

Source files
------------

// File: rtl/hdlc_pkg.sv
// Shared HDLC receive definitions: deframer states, bit classes and the
// run-length thresholds derived from the flag pattern.
package hdlc_pkg;

  typedef enum logic [1:0] {
    HUNT,
    FLAG,
    DATA
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_DATA,
    CLS_STUFF,
    CLS_FLAG,
    CLS_ABORT
  } bit_class_e;

  localparam logic [7:0] FLAG_BYTE  = 8'h7E;
  localparam logic [2:0] STUFF_ONES = 3'd5;
  localparam logic [2:0] ABORT_ONES = 3'd7;
  // A flag's closing zero follows exactly this many consecutive ones.
  localparam logic [2:0] FLAG_ONES  = 3'($countones(FLAG_BYTE));

endpackage

// File: rtl/hdlc_rx_destuff.sv
// Consecutive-ones tracker that classifies each sampled line bit as data,
// stuffed zero, flag, abort or nothing.
module hdlc_rx_destuff
  import hdlc_pkg::*;
(
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       clr_i,
  input  logic       bit_en_i,
  input  logic       bit_i,
  output bit_class_e cls_o
);

  logic [2:0] ones_q, ones_d;

  // Classification looks at the run length before this bit is counted.
  always_comb begin
    ones_d = ones_q;
    cls_o  = CLS_NONE;
    if (bit_en_i) begin
      if (bit_i) begin
        ones_d = (ones_q == ABORT_ONES) ? ones_q : ones_q + 3'd1;
        if (ones_q < STUFF_ONES)
          cls_o = CLS_DATA;
        else if (ones_q == ABORT_ONES - 3'd1)
          cls_o = CLS_ABORT;
      end else begin
        ones_d = 3'd0;
        if (ones_q < STUFF_ONES)
          cls_o = CLS_DATA;
        else if (ones_q == STUFF_ONES)
          cls_o = CLS_STUFF;
        else if (ones_q == FLAG_ONES)
          cls_o = CLS_FLAG;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      ones_q <= 3'd0;
    else if (clr_i)
      ones_q <= 3'd0;
    else
      ones_q <= ones_d;
  end

endmodule

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: hunts for flags, assembles destuffed bits into
// bytes and reports frame end, alignment/length errors and aborts.
module hdlc_rx_deframer
  import hdlc_pkg::*;
#(
  parameter int MAX_FRAME_BYTES = 128
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       en_i,
  input  logic       rxen_i,
  input  logic       rx_i,
  output logic [7:0] rxd_o,
  output logic       rxd_valid_o,
  output logic       eof_o,
  output logic       frame_err_o,
  output logic       abort_o
);

  localparam int BW = $clog2(MAX_FRAME_BYTES + 1);
  localparam logic [BW-1:0] MAX_CNT = BW'(MAX_FRAME_BYTES);

  bit_class_e    cls;
  state_e        state_q;
  logic [7:0]    shift_q;
  logic [7:0]    byte_d;
  logic [2:0]    bit_cnt_q;
  logic [BW-1:0] byte_cnt_q;

  hdlc_rx_destuff u_destuff (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .clr_i    (!en_i),
    .bit_en_i (en_i & rxen_i),
    .bit_i    (rx_i),
    .cls_o    (cls)
  );

  assign byte_d = {rx_i, shift_q[7:1]};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= HUNT;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= '0;
      rxd_o       <= 8'h00;
      rxd_valid_o <= 1'b0;
      eof_o       <= 1'b0;
      frame_err_o <= 1'b0;
      abort_o     <= 1'b0;
    end else begin
      rxd_valid_o <= 1'b0;
      eof_o       <= 1'b0;
      frame_err_o <= 1'b0;
      abort_o     <= 1'b0;
      if (!en_i) begin
        state_q    <= HUNT;
        shift_q    <= 8'h00;
        bit_cnt_q  <= 3'd0;
        byte_cnt_q <= '0;
      end else begin
        case (cls)
          // A closing flag also opens the next frame, so always land in FLAG.
          CLS_FLAG: begin
            if (state_q == DATA) begin
              if (bit_cnt_q == 3'd6)
                eof_o <= 1'b1;
              else
                frame_err_o <= 1'b1;
            end
            state_q    <= FLAG;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= '0;
          end
          CLS_ABORT: begin
            if (state_q == DATA)
              abort_o <= 1'b1;
            state_q <= HUNT;
          end
          CLS_DATA: begin
            if (state_q != HUNT) begin
              shift_q   <= byte_d;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (byte_cnt_q == MAX_CNT) begin
                  frame_err_o <= 1'b1;
                  state_q     <= HUNT;
                end else begin
                  rxd_o       <= byte_d;
                  rxd_valid_o <= 1'b1;
                  byte_cnt_q  <= byte_cnt_q + BW'(1);
                  state_q     <= DATA;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Self-checking bench for hdlc_rx_deframer: a default-size and a 4-byte-limit
// instance share one line; observed event logs are compared per scenario.
module tb_hdlc_rx_deframer;

  localparam int EV_EOF = 256;
  localparam int EV_ERR = 257;
  localparam int EV_ABT = 258;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic en = 1'b1;
  logic rxen = 1'b0;
  logic rx = 1'b0;
  logic rxen_s = 1'b0;

  logic [7:0] rxd [2];
  logic       vld [2];
  logic       eof [2];
  logic       err [2];
  logic       abt [2];

  int log0[$];
  int log1[$];
  int excl_viol [2];
  int lat_viol [2];
  int n_checks = 0;
  int n_fails = 0;

  always #5 clk = ~clk;

  hdlc_rx_deframer dut (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .rxen_i(rxen), .rx_i(rx),
    .rxd_o(rxd[0]), .rxd_valid_o(vld[0]), .eof_o(eof[0]),
    .frame_err_o(err[0]), .abort_o(abt[0])
  );

  hdlc_rx_deframer #(.MAX_FRAME_BYTES(4)) dut_small (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .rxen_i(rxen), .rx_i(rx),
    .rxd_o(rxd[1]), .rxd_valid_o(vld[1]), .eof_o(eof[1]),
    .frame_err_o(err[1]), .abort_o(abt[1])
  );

  function automatic void push_ev(input int d, input int ev);
    if (d == 0) log0.push_back(ev);
    else log1.push_back(ev);
  endfunction

  function automatic string fmt(input int q[$]);
    string s = "";
    foreach (q[i]) begin
      if (q[i] == EV_EOF) s = {s, "eof "};
      else if (q[i] == EV_ERR) s = {s, "err "};
      else if (q[i] == EV_ABT) s = {s, "abort "};
      else s = {s, $sformatf("%02h ", q[i][7:0])};
    end
    return s;
  endfunction

  always @(posedge clk) rxen_s <= rxen & en;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (vld[d]) push_ev(d, int'(rxd[d]));
      if (eof[d]) push_ev(d, EV_EOF);
      if (err[d]) push_ev(d, EV_ERR);
      if (abt[d]) push_ev(d, EV_ABT);
      if ((int'(eof[d]) + int'(err[d]) + int'(abt[d]) > 1) || (vld[d] && eof[d]))
        excl_viol[d]++;
      if ((vld[d] || eof[d] || err[d] || abt[d]) && !rxen_s)
        lat_viol[d]++;
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    rxen = 1'b1;
    @(posedge clk); #1;
    rxen = 1'b0;
    rx = 1'($urandom_range(0, 1));
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  task automatic send_raw(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic send_payload(input logic [7:0] p[$]);
    int ones = 0;
    foreach (p[k]) begin
      for (int i = 0; i < 8; i++) begin
        send_bit(p[k][i]);
        if (p[k][i]) begin
          ones++;
          if (ones == 5) begin send_bit(1'b0); ones = 0; end
        end else begin
          ones = 0;
        end
      end
    end
  endtask

  task automatic settle;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs;
    log0.delete();
    log1.delete();
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #2;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({rxd[d], vld[d], eof[d], err[d], abt[d]} !== 12'h000) begin
        n_fails++;
        $display("FAIL reset_state dut%0d: got %h, want 000", d, {rxd[d], vld[d], eof[d], err[d], abt[d]});
      end
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    n_checks++;
    if (log0.size() + log1.size() != 0) begin
      n_fails++;
      $display("FAIL reset_idle: got %0d events, want 0", log0.size() + log1.size());
    end
    $display("test_reset done");
  endtask

  task automatic test_single_byte;
    int exp[$];
    clear_logs();
    send_raw(8'h7E); send_raw(8'hA5); send_raw(8'h7E); settle();
    exp = '{'hA5, EV_EOF};
    n_checks++;
    if (fmt(log0) != fmt(exp)) begin n_fails++; $display("FAIL single_byte dut0: got [%s], want [%s]", fmt(log0), fmt(exp)); end
    n_checks++;
    if (fmt(log1) != fmt(exp)) begin n_fails++; $display("FAIL single_byte dut1: got [%s], want [%s]", fmt(log1), fmt(exp)); end
    $display("test_single_byte: 7E A5 7E -> [%s]", fmt(log0));
  endtask

  task automatic test_stuffing;
    int exp[$];
    logic [8:0] s = 9'b0_0001_1111;
    clear_logs();
    send_raw(8'h7E);
    for (int i = 0; i < 9; i++) send_bit(s[i]);
    send_raw(8'h7E); settle();
    exp = '{'h1F, EV_EOF};
    n_checks++;
    if (fmt(log0) != fmt(exp)) begin n_fails++; $display("FAIL stuffing dut0: got [%s], want [%s]", fmt(log0), fmt(exp)); end
    n_checks++;
    if (fmt(log1) != fmt(exp)) begin n_fails++; $display("FAIL stuffing dut1: got [%s], want [%s]", fmt(log1), fmt(exp)); end
    $display("test_stuffing: stuffed 1F -> [%s]", fmt(log0));
  endtask

  task automatic test_abort;
    int exp[$];
    clear_logs();
    send_raw(8'h7E); send_raw(8'hA5);
    repeat (7) send_bit(1'b1);
    settle();
    exp = '{'hA5, EV_ABT};
    n_checks++;
    if (fmt(log0) != fmt(exp)) begin n_fails++; $display("FAIL abort dut0: got [%s], want [%s]", fmt(log0), fmt(exp)); end
    n_checks++;
    if (fmt(log1) != fmt(exp)) begin n_fails++; $display("FAIL abort dut1: got [%s], want [%s]", fmt(log1), fmt(exp)); end
    clear_logs();
    send_raw(8'hA5); settle();
    n_checks++;
    if (log0.size() + log1.size() != 0) begin
      n_fails++;
      $display("FAIL abort_hunt: got [%s], want []", fmt(log0));
    end
    $display("test_abort: A5 + abort -> [%s]", fmt(exp));
  endtask

  task automatic test_misaligned;
    int exp[$];
    logic [10:0] bits = 11'b101_0101_1010;
    clear_logs();
    send_raw(8'h7E);
    for (int i = 0; i < 11; i++) send_bit(bits[i]);
    send_raw(8'h7E);
    send_raw(8'h3C); send_raw(8'h7E); settle();
    // 11 bits then the flag's six leading bits: 5A, spurious F5, error.
    exp = '{'h5A, 'hF5, EV_ERR, 'h3C, EV_EOF};
    n_checks++;
    if (fmt(log0) != fmt(exp)) begin n_fails++; $display("FAIL misaligned dut0: got [%s], want [%s]", fmt(log0), fmt(exp)); end
    n_checks++;
    if (fmt(log1) != fmt(exp)) begin n_fails++; $display("FAIL misaligned dut1: got [%s], want [%s]", fmt(log1), fmt(exp)); end
    $display("test_misaligned: 11 bits -> [%s]", fmt(log0));
  endtask

  task automatic test_flags_and_max;
    int exp0[$];
    int exp1[$];
    logic [7:0] p[$];
    clear_logs();
    send_raw(8'h7E); send_raw(8'h7E); send_raw(8'h7E);
    send_raw(8'h3C); send_raw(8'h7E);
    p = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_payload(p); send_raw(8'h7E);
    send_raw(8'h66); send_raw(8'h7E); settle();
    exp0 = '{'h3C, EV_EOF, 'h11, 'h22, 'h33, 'h44, 'h55, EV_EOF, 'h66, EV_EOF};
    exp1 = '{'h3C, EV_EOF, 'h11, 'h22, 'h33, 'h44, EV_ERR, 'h66, EV_EOF};
    n_checks++;
    if (fmt(log0) != fmt(exp0)) begin n_fails++; $display("FAIL flags_max dut0: got [%s], want [%s]", fmt(log0), fmt(exp0)); end
    n_checks++;
    if (fmt(log1) != fmt(exp1)) begin n_fails++; $display("FAIL flags_max dut1: got [%s], want [%s]", fmt(log1), fmt(exp1)); end
    $display("test_flags_and_max: max4 -> [%s]", fmt(log1));
  endtask

  task automatic test_enable;
    int exp[$];
    clear_logs();
    send_raw(8'h7E); send_raw(8'hA5);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    @(posedge clk); #1;
    en = 1'b0;
    for (int i = 0; i < 6; i++) send_bit(1'($urandom_range(0, 1)));
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (rxd[d] !== 8'hA5) begin
        n_fails++;
        $display("FAIL enable_hold dut%0d: got %02h, want a5", d, rxd[d]);
      end
    end
    en = 1'b1;
    send_raw(8'hC3); send_raw(8'h7E); send_raw(8'h81); send_raw(8'h7E); settle();
    exp = '{'hA5, 'h81, EV_EOF};
    n_checks++;
    if (fmt(log0) != fmt(exp)) begin n_fails++; $display("FAIL enable dut0: got [%s], want [%s]", fmt(log0), fmt(exp)); end
    n_checks++;
    if (fmt(log1) != fmt(exp)) begin n_fails++; $display("FAIL enable dut1: got [%s], want [%s]", fmt(log1), fmt(exp)); end
    $display("test_enable: -> [%s]", fmt(log0));
  endtask

  task automatic test_back_to_back;
    logic [7:0] p[$];
    int exp[$];
    int mx;
    string got;
    send_raw(8'h7E);
    for (int f = 0; f < 14; f++) begin
      clear_logs();
      p = {};
      repeat ($urandom_range(0, 7))
        p.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255)));
      send_payload(p);
      send_raw(8'h7E);
      settle();
      for (int d = 0; d < 2; d++) begin
        mx = (d == 0) ? 128 : 4;
        exp = {};
        if (p.size() > 0) begin
          for (int k = 0; k < p.size() && k < mx; k++) exp.push_back(int'(p[k]));
          exp.push_back((p.size() > mx) ? EV_ERR : EV_EOF);
        end
        got = (d == 0) ? fmt(log0) : fmt(log1);
        n_checks++;
        if (got != fmt(exp)) begin
          n_fails++;
          $display("FAIL frame%0d dut%0d: got [%s], want [%s]", f, d, got, fmt(exp));
        end
      end
      $display("frame %0d len %0d -> [%s]", f, p.size(), fmt(log0));
    end
  endtask

  task automatic test_reset_midframe;
    int exp[$];
    logic [7:0] b = 8'h3C;
    clear_logs();
    send_raw(8'h7E);
    for (int i = 0; i < 7; i++) send_bit(b[i]);
    rx = b[7];
    rxen = 1'b1;
    @(posedge clk); #2;
    rxen = 1'b0;
    rstn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({rxd[d], vld[d], eof[d], err[d], abt[d]} !== 12'h000) begin
        n_fails++;
        $display("FAIL async_reset dut%0d: got %h, want 000", d, {rxd[d], vld[d], eof[d], err[d], abt[d]});
      end
    end
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    send_raw(8'hA5);
    send_raw(8'h7E); send_raw(8'h55); send_raw(8'h7E); settle();
    exp = '{'h55, EV_EOF};
    n_checks++;
    if (fmt(log0) != fmt(exp)) begin n_fails++; $display("FAIL reset_midframe dut0: got [%s], want [%s]", fmt(log0), fmt(exp)); end
    n_checks++;
    if (fmt(log1) != fmt(exp)) begin n_fails++; $display("FAIL reset_midframe dut1: got [%s], want [%s]", fmt(log1), fmt(exp)); end
    $display("test_reset_midframe: -> [%s]", fmt(log0));
  endtask

  task automatic test_protocol;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (excl_viol[d] != 0) begin
        n_fails++;
        $display("FAIL exclusive_pulses dut%0d: got %0d overlaps, want 0", d, excl_viol[d]);
      end
      n_checks++;
      if (lat_viol[d] != 0) begin
        n_fails++;
        $display("FAIL output_latency dut%0d: got %0d stray pulses, want 0", d, lat_viol[d]);
      end
    end
    $display("test_protocol done");
  endtask

  initial begin
    excl_viol = '{0, 0};
    lat_viol = '{0, 0};
    test_reset();
    test_single_byte();
    test_stuffing();
    test_abort();
    test_misaligned();
    test_flags_and_max();
    test_enable();
    test_back_to_back();
    test_reset_midframe();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
